// File: rtl/calc_pkg.sv
// Shared types for the calculator operation scheduler.
// Op codes and scheduler FSM states.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } sched_state_t;

  function automatic logic is_add_op(op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/calc_op_sched_rr_arbiter.sv
// Combinational round-robin pick: first request at or above
// the pointer, wrapping to the low indices.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!o_any && i_req[i] && (IW'(i) >= i_ptr)) begin
        o_any    = 1'b1;
        o_gnt[i] = 1'b1;
        o_idx    = IW'(i);
      end
    end
    // wrap-around pass over indices below the pointer
    for (int i = 0; i < NREQ; i++) begin
      if (!o_any && i_req[i] && (IW'(i) < i_ptr)) begin
        o_any    = 1'b1;
        o_gnt[i] = 1'b1;
        o_idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/calc_op_sched.sv
// Round-robin scheduler sharing one add/sub unit and one multiply
// unit among NREQ requesters; one operation in flight at a time.
module calc_op_sched
  import calc_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int W           = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      result,
  output logic              err,
  output logic [W-1:0]      add_in1,
  output logic [W-1:0]      add_in2,
  output logic              add_sub,
  output logic              add_start,
  input  logic [W-1:0]      add_out,
  input  logic              add_finish,
  output logic [W-1:0]      mul_in1,
  output logic [W-1:0]      mul_in2,
  output logic              mul_start,
  input  logic [W-1:0]      mul_out,
  input  logic              mul_finish
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  sched_state_t    r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [NREQ-1:0] r_gnt;
  op_t             r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_add_sub;
  logic [W-1:0]    r_result;
  logic            r_err;
  logic [CW-1:0]   r_cnt;

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic [1:0]      w_sel_op;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  logic            w_fin;
  logic [W-1:0]    w_out;
  logic            w_tmo;
  logic [IW-1:0]   w_ptr_nxt;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == w_idx) begin
        w_sel_op = req_op[2*i +: 2];
        w_sel_a  = req_a[W*i +: W];
        w_sel_b  = req_b[W*i +: W];
      end
    end
  end

  // only the unit that was started is listened to
  always_comb begin
    w_fin = add_finish;
    w_out = add_out;
    if (r_op == OP_MUL) begin
      w_fin = mul_finish;
      w_out = mul_out;
    end
  end

  assign w_tmo = (r_cnt == CW'(TIMEOUT_CYC - 1));

  assign w_ptr_nxt = (r_idx == IW'(NREQ - 1)) ?
                     '0 : r_idx + 1'b1;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_gnt     <= '0;
      r_op      <= OP_ADD;
      r_a       <= '0;
      r_b       <= '0;
      r_add_sub <= 1'b0;
      r_result  <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt     <= w_gnt;
            r_idx     <= w_idx;
            r_op      <= op_t'(w_sel_op);
            r_a       <= w_sel_a;
            r_b       <= w_sel_b;
            r_add_sub <= (op_t'(w_sel_op) == OP_SUB);
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt <= '0;
          if (r_op == OP_RSV) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_fin) begin
            r_result <= w_out;
            r_err    <= 1'b0;
            r_state  <= S_RESP;
          end else if (w_tmo) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_ptr   <= w_ptr_nxt;
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign done    = (r_state == S_RESP) ? r_gnt : '0;
  assign result  = r_result;
  assign err     = r_err;
  assign add_in1 = r_a;
  assign add_in2 = r_b;
  assign add_sub = r_add_sub;
  assign mul_in1 = r_a;
  assign mul_in2 = r_b;

  assign add_start = (r_state == S_ISSUE) && is_add_op(r_op);
  assign mul_start = (r_state == S_ISSUE) && (r_op == OP_MUL);

endmodule

// File: tb/tb_calc_op_sched.sv
// Randomized scoreboard bench for calc_op_sched with behavioural
// add/mul unit models and a round-robin reference.
module tb_calc_op_sched;
  import calc_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 16;
  localparam int TMO  = 64;

  logic              clk  = 1'b0;
  logic              nRST = 1'b1;
  logic [NREQ-1:0]   req    = '0;
  logic [2*NREQ-1:0] req_op = '0;
  logic [W*NREQ-1:0] req_a  = '0;
  logic [W*NREQ-1:0] req_b  = '0;
  logic [NREQ-1:0]   gnt, done;
  logic [W-1:0]      result;
  logic              err;
  logic [W-1:0]      add_in1, add_in2, mul_in1, mul_in2;
  logic              add_sub, add_start, mul_start;
  logic [W-1:0]      add_out = '0;
  logic [W-1:0]      mul_out = '0;
  logic              add_finish = 1'b0;
  logic              mul_finish = 1'b0;

  always #5 clk = ~clk;

  calc_op_sched #(.NREQ(NREQ), .W(W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .nRST(nRST),
    .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .done(done), .result(result), .err(err),
    .add_in1(add_in1), .add_in2(add_in2), .add_sub(add_sub),
    .add_start(add_start), .add_out(add_out), .add_finish(add_finish),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_start(mul_start),
    .mul_out(mul_out), .mul_finish(mul_finish)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    bit           drop;
  } stim_t;

  stim_t stim_q[NREQ][$];
  stim_t exp_q[NREQ][$];
  bit    cur_drop[NREQ];

  int checks = 0;
  int errors = 0;
  int stray_add_req = 0, stray_add_ack = 0;
  int stray_mul_req = 0, stray_mul_ack = 0;

  logic [NREQ-1:0] req_pos = '0;
  logic [NREQ-1:0] prev_gnt = '0;
  int  mptr = 0;
  bit  in_op = 0;
  int  own = 0, starts = 0, cyc = 0;
  int  add_cnt = 0, mul_cnt = 0;
  logic [W-1:0] add_val = '0, mul_val = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exv, $time);
    end
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // expected {err, result} straight from the operation's arithmetic
  function automatic logic [W:0] model(input stim_t s);
    logic [W-1:0]   r;
    logic [2*W-1:0] p;
    if (s.op == 2'b11 || s.lat == 0) return {1'b1, {W{1'b0}}};
    case (s.op)
      2'b00:   r = s.a + s.b;
      2'b01:   r = s.a - s.b;
      default: begin p = s.a * s.b; r = p[W-1:0]; end
    endcase
    return {1'b0, r};
  endfunction

  function automatic int exp_cyc(input stim_t s);
    if (s.op == 2'b11) return 1;
    if (s.lat == 0) return TMO + 1;
    return s.lat + 1;
  endfunction

  always @(posedge clk) req_pos = req;

  // requesters: hold req until own done; reload back-to-back if queued
  always @(negedge clk) begin
    if (!nRST) begin
      req = '0;
      for (int i = 0; i < NREQ; i++) begin
        stim_q[i].delete();
        exp_q[i].delete();
        cur_drop[i] = 0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (cur_drop[i] && gnt[i]) begin
          req[i] = 1'b0;
          cur_drop[i] = 0;
        end
        if (done[i] || exp_q[i].size() == 0) begin
          if (stim_q[i].size() > 0) begin
            stim_t s;
            s = stim_q[i].pop_front();
            req_op[2*i +: 2] = s.op;
            req_a[W*i +: W]  = s.a;
            req_b[W*i +: W]  = s.b;
            cur_drop[i] = s.drop;
            exp_q[i].push_back(s);
            req[i] = 1'b1;
          end else if (done[i]) begin
            req[i] = 1'b0;
          end
        end
      end
    end
  end

  // add and multiply unit models with per-operation latency
  always @(negedge clk) begin
    add_finish = 1'b0;
    mul_finish = 1'b0;
    add_out = W'($urandom);
    mul_out = W'($urandom);
    if (!nRST) begin
      add_cnt = 0;
      mul_cnt = 0;
    end else begin
      int o, l;
      if (add_cnt > 0) begin
        add_cnt--;
        if (add_cnt == 0) begin add_finish = 1'b1; add_out = add_val; end
      end
      if (mul_cnt > 0) begin
        mul_cnt--;
        if (mul_cnt == 0) begin mul_finish = 1'b1; mul_out = mul_val; end
      end
      o = idx_of(gnt);
      l = (exp_q[o].size() > 0) ? exp_q[o][0].lat : 1;
      if (add_start) begin
        add_cnt = l;
        add_val = add_sub ? add_in1 - add_in2 : add_in1 + add_in2;
      end
      if (mul_start) begin
        logic [2*W-1:0] p;
        p = mul_in1 * mul_in2;
        mul_cnt = l;
        mul_val = p[W-1:0];
      end
      if (stray_add_req != stray_add_ack) begin
        add_finish = 1'b1;
        stray_add_ack++;
      end
      if (stray_mul_req != stray_mul_ack) begin
        mul_finish = 1'b1;
        stray_mul_ack++;
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!nRST) begin
      chk("rst_gnt_done", {gnt, done}, 0);
      chk("rst_res_err", {err, result}, 0);
      chk("rst_add", {add_start, add_sub, add_in1, add_in2}, 0);
      chk("rst_mul", {mul_start, mul_in1, mul_in2}, 0);
      mptr = 0;
      in_op = 0;
      prev_gnt = '0;
    end else begin
      if (gnt != 0 && prev_gnt == 0) begin
        int j;
        j = rr_pick(req_pos, mptr);
        chk("grant_rr", gnt, (j < 0) ? 64'd0 : (64'd1 << j));
        own = idx_of(gnt);
        in_op = 1;
        starts = 0;
        cyc = 0;
      end else if (in_op) begin
        cyc++;
        chk("gnt_hold", gnt, 64'd1 << own);
      end
      if (add_start || mul_start) begin
        starts++;
        if (in_op && exp_q[own].size() > 0) begin
          stim_t e;
          e = exp_q[own][0];
          chk("start_kind", {add_start, mul_start},
              (e.op == 2'b10) ? 2'b01 : 2'b10);
          if (add_start) begin
            chk("add_sub", add_sub, e.op == 2'b01);
            chk("add_ops", {add_in1, add_in2}, {e.a, e.b});
          end else begin
            chk("mul_ops", {mul_in1, mul_in2}, {e.a, e.b});
          end
        end
      end
      if (done != 0) begin
        if (!in_op || exp_q[own].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got done=%0b expected none", done);
        end else begin
          stim_t e;
          logic [W:0] m;
          e = exp_q[own].pop_front();
          m = model(e);
          chk("done_vec", done, 64'd1 << own);
          chk("result", result, m[W-1:0]);
          chk("err", err, m[W]);
          chk("starts", starts, (e.op == 2'b11) ? 0 : 1);
          chk("latency", cyc, exp_cyc(e));
          mptr = (own + 1) % NREQ;
          in_op = 0;
        end
      end
      prev_gnt = gnt;
    end
  end

  task automatic push(input int r, input logic [1:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input int lat, input bit drop);
    stim_t s;
    s.op = op; s.a = a; s.b = b; s.lat = lat; s.drop = drop;
    stim_q[r].push_back(s);
  endtask

  function automatic bit busy();
    for (int i = 0; i < NREQ; i++)
      if (stim_q[i].size() > 0 || exp_q[i].size() > 0) return 1;
    return in_op;
  endfunction

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy() && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #2;
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d cycles, required < %0d",
               nm, n, budget);
    end
  endtask

  initial begin
    #1 nRST = 1'b0;
    repeat (3) @(negedge clk);
    #2 nRST = 1'b1;

    push(0, 2'b00, 16'd12, 16'd30, 4, 0);
    wait_idle("add", 200);

    push(1, 2'b01, 16'd5, 16'd9, 2, 0);
    push(1, 2'b10, 16'd123, 16'd10, 3, 0);
    wait_idle("submul", 200);

    for (int k = 0; k < 4; k++) begin
      push(0, 2'($urandom_range(0, 2)), W'($urandom), W'($urandom), 2, 0);
      push(1, 2'($urandom_range(0, 2)), W'($urandom), W'($urandom), 1, 0);
    end
    wait_idle("rr", 400);

    push(0, 2'b10, 16'd3, 16'd4, 0, 0);
    wait_idle("tmo", 400);
    stray_mul_req++;
    repeat (6) @(negedge clk);
    #2;

    push(1, 2'b11, 16'd1, 16'd2, 1, 0);
    wait_idle("illegal", 200);
    stray_add_req++;
    repeat (6) @(negedge clk);
    #2;

    push(0, 2'b00, 16'hFFFF, 16'd1, 1, 1);
    wait_idle("drop", 200);

    push(0, 2'b10, 16'd7, 16'd7, 0, 0);
    repeat (12) @(negedge clk);
    #2 nRST = 1'b0;
    repeat (3) @(negedge clk);
    #2 nRST = 1'b1;
    repeat (80) @(negedge clk);
    #2;
    push(1, 2'b00, 16'd100, 16'd23, 2, 0);
    wait_idle("post_reset", 200);

    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < 8; k++) begin
        logic [1:0] op;
        op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        push(int'($urandom_range(0, NREQ - 1)), op, W'($urandom),
             W'($urandom), int'($urandom_range(1, 6)),
             $urandom_range(0, 3) == 0);
      end
      wait_idle("random", 1000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
